// File: rtl/simd_lane_skid_reg.sv
// Multi-lane pipeline stage with valid/ready handshake, 2-entry skid buffer
// and per-lane write masking against a persistent lane state.
module simd_lane_skid_reg #(
  parameter int unsigned W     = 16,
  parameter int unsigned LANES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_data,
  input  logic [LANES-1:0]     in_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_data,
  output logic [LANES-1:0]     out_mask,
  output logic [1:0]           count
);

  localparam int unsigned DW = LANES * W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [DW-1:0]    r_lane;
  logic [DW-1:0]    r_main_data;
  logic [LANES-1:0] r_main_mask;
  logic [DW-1:0]    r_skid_data;
  logic [LANES-1:0] r_skid_mask;

  logic [DW-1:0]    w_lane_nxt;
  logic [DW-1:0]    w_main_data_nxt;
  logic [LANES-1:0] w_main_mask_nxt;
  logic [DW-1:0]    w_skid_data_nxt;
  logic [LANES-1:0] w_skid_mask_nxt;
  logic [DW-1:0]    w_merged;
  logic             w_accept;
  logic             w_pop;

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = r_out_valid & out_ready;

  // Masked-off lanes take the last written value of that lane.
  always_comb begin
    w_merged = r_lane;
    for (int i = 0; i < int'(LANES); i++) begin
      if (in_mask[i]) w_merged[i*W +: W] = in_data[i*W +: W];
    end
  end

  // Next-state and storage update; flush discards the incoming word.
  always_comb begin
    w_state_nxt     = r_state;
    w_lane_nxt      = r_lane;
    w_main_data_nxt = r_main_data;
    w_main_mask_nxt = r_main_mask;
    w_skid_data_nxt = r_skid_data;
    w_skid_mask_nxt = r_skid_mask;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      if (w_accept) w_lane_nxt = w_merged;
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt     = ST_ONE;
            w_main_data_nxt = w_merged;
            w_main_mask_nxt = in_mask;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            w_main_data_nxt = w_merged;
            w_main_mask_nxt = in_mask;
          end else if (w_accept) begin
            w_state_nxt     = ST_TWO;
            w_skid_data_nxt = w_merged;
            w_skid_mask_nxt = in_mask;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_state_nxt     = ST_ONE;
            w_main_data_nxt = r_skid_data;
            w_main_mask_nxt = r_skid_mask;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // All state advances on the falling edge of clk.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_lane      <= '0;
      r_main_data <= '0;
      r_main_mask <= '0;
      r_skid_data <= '0;
      r_skid_mask <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_TWO);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_lane      <= w_lane_nxt;
      r_main_data <= w_main_data_nxt;
      r_main_mask <= w_main_mask_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_mask <= w_skid_mask_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;
  assign out_mask  = r_main_mask;
  assign count     = r_state;

endmodule
